// File: rtl/vram_pkg.sv
// Shared widths and the queued-entry layout for the host VRAM write path.
package vram_pkg;

  localparam int unsigned VRAM_WORD_ADDR_W = 15;
  localparam int unsigned VRAM_BANK_ADDR_W = 14;
  localparam int unsigned VRAM_DATA_W      = 16;
  localparam int unsigned VRAM_INC_W       = 8;

  typedef struct packed {
    logic [VRAM_WORD_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0]      data;
  } vram_entry_t;

  // Word address LSB picks the bank; the remaining bits address within it.
  function automatic logic [VRAM_BANK_ADDR_W-1:0] bank_addr(input logic [VRAM_WORD_ADDR_W-1:0] a);
    return a[VRAM_WORD_ADDR_W-1:1];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; head word is visible on o_rdata.
module sync_fifo #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vram_write_queue.sv
// Host VRAM write buffer: auto-incrementing word pointer, queued writes drained
// into the even/odd banks one word per granted scheduler slot.
module vram_write_queue
  import vram_pkg::*;
#(
  parameter int unsigned           DEPTH     = 8,
  parameter logic [VRAM_INC_W-1:0] INC_RESET = 8'd1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        host_address_write,
  input  logic [VRAM_WORD_ADDR_W-1:0] host_address,
  input  logic [VRAM_INC_W-1:0]       host_increment,
  input  logic                        host_data_write,
  input  logic [VRAM_DATA_W-1:0]      host_data,
  output logic                        host_ready,
  output logic                        host_overflow,
  input  logic                        vram_slot,
  output logic [VRAM_BANK_ADDR_W-1:0] vram_even_address,
  output logic [VRAM_BANK_ADDR_W-1:0] vram_odd_address,
  output logic                        vram_even_write_en,
  output logic                        vram_odd_write_en,
  output logic [2*VRAM_DATA_W-1:0]    vram_write_data,
  output logic                        pending
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [VRAM_WORD_ADDR_W-1:0] r_ptr;
  logic [VRAM_INC_W-1:0]       r_inc;
  logic                        r_overflow;

  logic [VRAM_WORD_ADDR_W-1:0] w_addr;
  logic [VRAM_INC_W-1:0]       w_step;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_full;
  logic                        w_empty;
  logic [CW-1:0]               w_count;
  vram_entry_t                 w_push_entry;
  vram_entry_t                 w_head;

  // A same-cycle address write supplies both the address and the step of the push.
  assign w_addr       = host_address_write ? host_address : r_ptr;
  assign w_step       = host_address_write ? host_increment : r_inc;
  assign w_push       = host_data_write && !w_full;
  assign w_pop        = vram_slot && !w_empty;
  assign w_push_entry = '{addr: w_addr, data: host_data};

  sync_fifo #(
    .WIDTH ($bits(vram_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign host_ready    = (w_count != CW'(DEPTH));
  assign host_overflow = r_overflow;
  assign pending       = !w_empty || vram_even_write_en || vram_odd_write_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_inc      <= INC_RESET;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)                  r_ptr <= w_addr + VRAM_WORD_ADDR_W'(w_step);
      else if (host_address_write) r_ptr <= host_address;
      if (host_address_write)      r_inc <= host_increment;
      if (host_address_write)      r_overflow <= 1'b0;
      else if (host_data_write && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vram_even_address  <= '0;
      vram_odd_address   <= '0;
      vram_even_write_en <= 1'b0;
      vram_odd_write_en  <= 1'b0;
      vram_write_data    <= '0;
    end else begin
      vram_even_write_en <= w_pop && !w_head.addr[0];
      vram_odd_write_en  <= w_pop &&  w_head.addr[0];
      if (w_pop) begin
        vram_write_data <= {w_head.data, w_head.data};
        if (w_head.addr[0]) vram_odd_address  <= bank_addr(w_head.addr);
        else                vram_even_address <= bank_addr(w_head.addr);
      end
    end
  end

endmodule
